// File: rtl/trojan0_leak_decoder_pkg.sv
// Shared constants for the Trojan0 leak channel: replica LFSR definition,
// decoder FSM states and small helper functions used by the receiver.
package trojan_pkg;

    localparam int              LFSR_W    = 20;
    localparam logic [19:0]     LFSR_SEED = 20'h03031;

    // Feedback taps of the leaking LFSR (new bit enters at the MSB).
    localparam int              TAP_A     = 15;
    localparam int              TAP_B     = 11;
    localparam int              TAP_C     = 7;
    localparam int              TAP_D     = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // One step of the keystream generator, identical to the leaking block.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic fb;
        fb = cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D];
        return {fb, cur[LFSR_W-1:1]};
    endfunction

    // A leaked byte is trustworthy only when all eight copies of the bit agree.
    function automatic logic byte_uniform(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/trojan0_leak_decoder_lfsr.sv
// Local replica of the leaking block's keystream LFSR. Exposes the current
// state, a one-cycle-delayed copy that lines up with the registered leak bus,
// and a flag that marks the delayed copy as meaningful.
module leak_lfsr_replica
    import trojan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] s,
    output logic [LFSR_W-1:0] s_d,
    output logic              primed
);

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_dly_q;
    logic              primed_q;

    // Free-running keystream state, reseeded together with the leaking block.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= LFSR_SEED;
        end else begin
            s_q <= lfsr_next(s_q);
        end
    end

    // Delayed keystream pairing with the leak bus, and the first-edge prime flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_dly_q  <= LFSR_SEED;
            primed_q <= 1'b0;
        end else begin
            s_dly_q  <= s_q;
            primed_q <= 1'b1;
        end
    end

    assign s      = s_q;
    assign s_d    = s_dly_q;
    assign primed = primed_q;

endmodule

// File: rtl/trojan0_leak_decoder.sv
// Attacker-side recovery engine for the Trojan0 key leak. Strips the replica
// keystream from each leaked byte lane, rejects lanes whose eight copies
// disagree, and majority-votes key[7:0] over WINDOW accepted samples.
module trojan0_leak_decoder
    import trojan_pkg::*;
#(
    parameter int WINDOW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] load_in,
    input  logic        in_valid,
    input  logic        start,
    output logic        busy,
    output logic        key_valid,
    output logic [7:0]  key_out,
    output logic [15:0] err_cnt
);

    localparam int               CNT_W  = $clog2(WINDOW) + 1;
    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(WINDOW / 2);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [LFSR_W-1:0] s_s;
    logic [LFSR_W-1:0] s_d_s;
    logic              primed_s;
    logic              unused_s;

    logic [7:0]        kb_s;
    logic              consistent_s;
    logic              observe_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  vote_q [8];
    logic [CNT_W-1:0]  vote_d [8];
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [15:0]       err_q,   err_d;
    logic              busy_q,  busy_d;
    logic              kv_q,    kv_d;
    logic [7:0]        key_q,   key_d;

    leak_lfsr_replica u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .s      (s_s),
        .s_d    (s_d_s),
        .primed (primed_s)
    );

    // Only the low byte of the delayed keystream masks the key bits.
    assign unused_s = ^{s_s, s_d_s[LFSR_W-1:8]};

    // Per-lane consistency check and keystream removal.
    always_comb begin
        consistent_s = 1'b1;
        kb_s         = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (!byte_uniform(load_in[8*j +: 8])) begin
                consistent_s = 1'b0;
            end else begin
                consistent_s = consistent_s;
            end
            kb_s[j] = load_in[8*j] ^ s_d_s[j];
        end
    end

    assign observe_s = in_valid && primed_s;

    // Next-state logic for the recovery FSM, vote counters and error counter.
    always_comb begin
        state_d = state_q;
        vote_d  = vote_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        kv_d    = 1'b0;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    for (int j = 0; j < 8; j++) begin
                        vote_d[j] = '0;
                    end
                    cnt_d  = '0;
                    err_d  = 16'h0000;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (observe_s && consistent_s) begin
                    for (int j = 0; j < 8; j++) begin
                        vote_d[j] = vote_q[j] + CNT_W'(kb_s[j]);
                    end
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_q == (WIN_C - ONE_C)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (observe_s) begin
                    // Rejected observation: count it, saturating.
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'h0001;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: begin
                // Strict majority; an exact tie resolves to 0.
                for (int j = 0; j < 8; j++) begin
                    key_d[j] = (vote_q[j] > HALF_C);
                end
                kv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int j = 0; j < 8; j++) begin
                vote_q[j] <= '0;
            end
            cnt_q   <= '0;
            err_q   <= 16'h0000;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
            key_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            vote_q  <= vote_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
            key_q   <= key_d;
        end
    end

    assign busy      = busy_q;
    assign key_valid = kv_q;
    assign key_out   = key_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_trojan0_leak_decoder.sv
// Directed bench for trojan0_leak_decoder. A small model of the leaking block
// (independent LFSR, registered leak bus, key 8'hA5) shares clk/rst with the
// decoder; the bench perturbs the bus with an XOR mask to create faults.
module tb_trojan0_leak_decoder;

    logic        clk;
    logic        rst;
    logic [63:0] load_in;
    logic        in_valid;
    logic        start;
    logic        busy;
    logic        key_valid;
    logic [7:0]  key_out;
    logic [15:0] err_cnt;

    logic [63:0] flip;
    logic [19:0] lk_s;
    logic [63:0] lk_load;
    logic [7:0]  leak_key;

    int tests;
    int fails;

    trojan0_leak_decoder #(.WINDOW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_in   (load_in),
        .in_valid  (in_valid),
        .start     (start),
        .busy      (busy),
        .key_valid (key_valid),
        .key_out   (key_out),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial leak_key = 8'hA5;

    // Leaking block model: LFSR plus registered leak bus, one cycle behind.
    always @(posedge clk) begin
        if (rst) begin
            lk_s    <= 20'h03031;
            lk_load <= 64'h0;
        end else begin
            lk_s <= {lk_s[15] ^ lk_s[11] ^ lk_s[7] ^ lk_s[0], lk_s[19:1]};
            for (int j = 0; j < 8; j++) begin
                lk_load[8*j +: 8] <= {8{leak_key[j] ^ lk_s[j]}};
            end
        end
    end

    assign load_in = lk_load ^ flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive start at the current negedge, then feed the chosen pattern until
    // key_valid appears; check latency, key, error count and pulse width.
    task automatic run_recovery(input string tag, input int mode, input logic [63:0] start_flip,
                                input int exp_cyc, input logic [7:0] exp_key,
                                input logic [15:0] exp_err);
        int cyc;
        cyc      = -1;
        start    = 1'b1;
        in_valid = 1'b1;
        flip     = start_flip;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
            if (mode == 1 && k == 4) check({tag, "_err_mid"}, {16'd0, err_cnt}, 32'd1);
            if (mode == 3 && k == 11) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            if (key_valid) begin
                cyc = k;
                break;
            end
            in_valid = 1'b1;
            flip     = 64'h0;
            case (mode)
                1: if (k == 3 || k == 6 || k == 9) flip = 64'h8;
                2: if (k <= 8) flip = 64'hFF;
                3: begin
                    in_valid = (k % 2 == 0);
                    if (k == 10) start = 1'b1;
                end
                default: flip = 64'h0;
            endcase
        end
        in_valid = 1'b0;
        flip     = 64'h0;
        check({tag, "_latency"}, cyc, exp_cyc);
        if (cyc > 0) begin
            check({tag, "_key"}, {24'd0, key_out}, {24'd0, exp_key});
            check({tag, "_err"}, {16'd0, err_cnt}, {16'd0, exp_err});
            check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({tag, "_kv_pulse"}, {31'd0, key_valid}, 32'd0);
            check({tag, "_key_hold"}, {24'd0, key_out}, {24'd0, exp_key});
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        flip     = 64'h0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_kv", {31'd0, key_valid}, 32'd0);
        check("rst_key", {24'd0, key_out}, 32'd0);
        check("rst_err", {16'd0, err_cnt}, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("lfsr_first_step", {12'd0, dut.u_lfsr.s}, 32'h81818);
        @(negedge clk);

        // Continuous clean input: 1 + 16 + 1 cycles.
        run_recovery("basic", 0, 64'h0, 18, 8'hA5, 16'd0);
        // Three rejected samples delay completion by three cycles.
        run_recovery("incons", 1, 64'h0, 21, 8'hA5, 16'd3);
        // Byte 0 inverted on half the window: bit 0 ties and resolves to 0.
        run_recovery("tie", 2, 64'h0, 18, 8'hA4, 16'd0);
        // Alternating valid, plus an ignored start mid-collect.
        run_recovery("gapped", 3, 64'h0, 34, 8'hA5, 16'd0);

        // Reset after five accepted samples (one rejected among them).
        start    = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            flip  = (k == 3) ? 64'h8 : 64'h0;
        end
        @(negedge clk);
        check("mid_err_before", {16'd0, err_cnt}, 32'd1);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst  = 1'b1;
        flip = 64'h8;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_key", {24'd0, key_out}, 32'd0);
        check("mid_rst_err", {16'd0, err_cnt}, 32'd0);

        // Garbage valid during reset and the following cycle, with start on
        // the first non-reset edge; none of it may vote or count as an error.
        rst = 1'b0;
        run_recovery("preprime", 0, 64'h8, 18, 8'hA5, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
